pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program counter for the instruction-fetch stage. It holds the PC and
//  selects the next PC each cycle: sequential, conditional branch, absolute jump or register jump.
//  A BOOT/RUN/HALT state machine gates fetch and supports stall. Feeds instruction memory address and
//  the PC+INC value used by the link and branch paths.
// PARAMETERS
//  ADDR_W        32           PC width in bits; must be >= 16
//  INC           4            sequential increment (bytes per instruction)
//  RESET_VECTOR  32'h0        PC value loaded on reset
//  RAS_DEPTH     4            return-address-stack entries (used only with PC_RAS_EN)
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-high reset
//  stall       in   1          1 = hold PC; all selects ignored
//  halt        in   1          RUN->HALT request
//  resume      in   1          HALT->RUN request
//  mode        in   2          00 SEQ, 01 BRANCH, 10 JUMP, 11 JREG
//  br_taken    in   1          qualifies BRANCH; 0 behaves as SEQ
//  br_imm      in   16         signed word offset for BRANCH
//  j_target    in   ADDR_W-6   word target for JUMP
//  reg_target  in   ADDR_W     target for JREG
//  call        in   1          push return address (PC_RAS_EN only)
//  ret         in   1          pop with JREG (PC_RAS_EN only)
//  pc_q        out  ADDR_W     current PC
//  pc_plus     out  ADDR_W     pc_q + INC (combinational)
//  pc_valid    out  1          1 = pc_q is a valid fetch address this cycle
//  ras_top     out  ADDR_W     predicted return address
//  ras_hit     out  1          ras_top == reg_target while ret is asserted
//  ras_empty   out  1          stack holds no entries
// BEHAVIOUR
//  - Reset (async, any time, including mid-HALT or mid-stall): pc_q=RESET_VECTOR, state=BOOT, pc_valid=0,
//    RAS cleared, ras_empty=1, ras_top=0, ras_hit=0.
//  - BOOT: one cycle with pc_valid=0 and PC held; always goes to RUN on the next edge.
//  - RUN: pc_valid=1. If stall=1, PC, state and RAS all hold. Otherwise, on the next edge:
//    - halt=1: go to HALT. PC still advances per mode this cycle.
//    - pc_q <= next PC, selected by mode:
//      SEQ: pc_plus.
//      BRANCH: br_taken ? pc_plus + (sext(br_imm) << 2) : pc_plus.
//      JUMP: {pc_plus[ADDR_W-1 -: 4], j_target, 2'b00}.
//      JREG: reg_target.
//  - HALT: pc_valid=0 and PC holds. resume=1 goes to RUN on the next edge. halt and resume both high:
//    halt wins in RUN, resume wins in HALT.
//  - Arithmetic is modulo 2^ADDR_W: wraps silently at the top of the address space and below zero.
//  - Latency: selects are sampled at edge N; the new pc_q is visible after edge N. pc_plus has zero latency.
// CONFIGURATION
//  - PC_RAS_EN defined: RAS_DEPTH-entry circular return-address stack. Updates only in RUN with stall=0.
//    - call=1: push pc_plus. When full, the oldest entry is overwritten and ras_empty stays 0.
//    - ret=1 with mode=JREG: pop. Popping while empty is ignored.
//    - call and ret together: pop then push, so the count is unchanged and the top becomes the new pc_plus.
//    - ras_top is the current top entry (0 when empty). ras_hit is combinational.
//    - Next PC is always reg_target; the RAS predicts only.
//  - PC_RAS_EN undefined: no stack storage. call and ret are ignored; ras_top=0, ras_hit=0, ras_empty=1.
// TESTING
//  - Reset with RESET_VECTOR=0x100, release reset -> 1 cycle pc_q=0x100 with pc_valid=0, then
//    SEQ: 0x100, 0x104, 0x108 with pc_valid=1.
//  - pc_q=0x200, BRANCH, br_taken=1, br_imm=-2 -> 0x1FC; with br_taken=0 -> 0x204.
//  - pc_q=0x1000_0000, JUMP, j_target=0x40 -> 0x1000_0100; JREG, reg_target=0xABC0 -> 0xABC0.
//  - Hold stall=1 for 3 cycles at pc_q=0x20 -> pc_q stays 0x20; halt, wait 2 cycles, resume -> pc_valid
//    is 0 for 2 cycles, then SEQ continues from the held PC.
//  - Assert reset mid-HALT -> pc_q=RESET_VECTOR at once (no clock edge), state=BOOT.
//    With ADDR_W=16 at pc_q=0xFFFC, SEQ -> 0x0000.
//  - PC_RAS_EN, RAS_DEPTH=2: 3 calls at 0x10, 0x20, 0x30 -> 3 rets give ras_top 0x34, then 0x24, then
//    ras_empty=1. Each ret with reg_target=ras_top gives ras_hit=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter for the instruction-fetch stage.
// Holds the PC and picks the next one each cycle from four sources:
// sequential, conditional branch, absolute jump or register jump.
// A BOOT/RUN/HALT state machine decides when the PC is a valid fetch address.
// Optional feature: define PC_RAS_EN to build a circular return-address
// stack that predicts register-jump targets. Without it the stack outputs
// are tied off (ras_top=0, ras_hit=0, ras_empty=1).
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       INC          = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  input  logic [1:0]        mode,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic [ADDR_W-7:0] j_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc_q,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_hit,
  output logic              ras_empty
);

  localparam logic [1:0] MODE_SEQ    = 2'b00;
  localparam logic [1:0] MODE_BRANCH = 2'b01;
  localparam logic [1:0] MODE_JUMP   = 2'b10;
  localparam logic [1:0] MODE_JREG   = 2'b11;

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              advance;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_dest;
  logic [ADDR_W-1:0] jump_dest;

  // Sequential address and the path-specific candidate targets. All of this
  // is modulo 2^ADDR_W, so overflow and underflow simply wrap.
  assign pc_plus   = pc_q + INC_W;
  assign br_offset = ADDR_W'($signed(br_imm)) << 2;
  assign br_dest   = pc_plus + br_offset;
  assign jump_dest = {pc_plus[ADDR_W-1 -: 4], j_target, 2'b00};

  // State register; reset parks the sequencer in BOOT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, fetch-valid flag and the PC advance enable. Halt is checked
  // before resume in RUN, and only resume matters in HALT, which gives the
  // "halt wins in RUN, resume wins in HALT" priority.
  always_comb begin
    state_d  = state_q;
    pc_valid = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        pc_valid = 1'b1;
        if (!stall) begin
          advance = 1'b1;
          if (halt) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Next-PC selection; a branch that is not taken falls back to sequential.
  always_comb begin
    pc_next = pc_plus;
    case (mode)
      MODE_SEQ:    pc_next = pc_plus;
      MODE_BRANCH: pc_next = br_taken ? br_dest : pc_plus;
      MODE_JUMP:   pc_next = jump_dest;
      MODE_JREG:   pc_next = reg_target;
      default:     pc_next = pc_plus;
    endcase
  end

  // PC register; it only moves while running and not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else if (advance) begin
      pc_q <= pc_next;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;
  logic [CNT_W-1:0]  ras_cnt_q;
  logic              ras_push;
  logic              ras_pop;

  // The stack only changes on cycles where the PC itself advances. A pop
  // needs a register jump and at least one live entry; popping an empty
  // stack is silently dropped.
  assign ras_push = advance && call;
  assign ras_pop  = advance && ret && (mode == MODE_JREG) && (ras_cnt_q != '0);
  assign ptr_inc  = (ras_ptr_q == PTR_LAST) ? '0 : ras_ptr_q + PTR_W'(1);
  assign ptr_dec  = (ras_ptr_q == '0) ? PTR_LAST : ras_ptr_q - PTR_W'(1);

  // Circular stack: ras_ptr_q names the top slot. Pushing onto a full stack
  // wraps over the oldest entry and leaves the count saturated. A combined
  // pop+push just replaces the top slot in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        ras_mem[i] <= '0;
      end
    end else if (ras_push && ras_pop) begin
      ras_mem[ras_ptr_q] <= pc_plus;
    end else if (ras_push) begin
      ras_ptr_q        <= ptr_inc;
      ras_mem[ptr_inc] <= pc_plus;
      if (ras_cnt_q != CNT_FULL) begin
        ras_cnt_q <= ras_cnt_q + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr_q <= ptr_dec;
      ras_cnt_q <= ras_cnt_q - CNT_W'(1);
    end
  end

  // Prediction outputs; stale slots below the count are masked to zero.
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr_q];
  assign ras_hit   = ret && (ras_top == reg_target);
`else
  logic unused_ras_inputs;

  // No stack storage: call/ret have no effect and the outputs are constant.
  assign unused_ras_inputs = &{1'b0, call, ret};
  assign ras_empty         = 1'b1;
  assign ras_top           = '0;
  assign ras_hit           = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Directed boot/stall/halt/reset sequences, a table of next-PC vectors,
// a 16-bit wrap check on a second instance, and a randomized run against
// an arithmetic reference model. Stack checks follow PC_RAS_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [1:0]  mode;
  logic        br_taken;
  logic [15:0] br_imm;
  logic [25:0] j_target;
  logic [31:0] reg_target;
  logic        call;
  logic        ret;
  logic [31:0] pc_q;
  logic [31:0] pc_plus;
  logic        pc_valid;
  logic [31:0] ras_top;
  logic        ras_hit;
  logic        ras_empty;

  logic [1:0]  s_mode;
  logic        s_ctl;
  logic [15:0] s_imm;
  logic [9:0]  s_j_target;
  logic [15:0] s_reg_target;
  logic [15:0] s_pc_q;
  logic [15:0] s_pc_plus;
  logic        s_pc_valid;
  logic [15:0] s_ras_top;
  logic        s_ras_hit;
  logic        s_ras_empty;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic        taken;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rt;
    logic [31:0] start;
    logic [31:0] expect_pc;
  } vec_t;

  vec_t vecs[10];

  pc_sequencer #(
    .ADDR_W(32), .INC(4), .RESET_VECTOR(RV), .RAS_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .mode(mode), .br_taken(br_taken), .br_imm(br_imm), .j_target(j_target),
    .reg_target(reg_target), .call(call), .ret(ret), .pc_q(pc_q),
    .pc_plus(pc_plus), .pc_valid(pc_valid), .ras_top(ras_top),
    .ras_hit(ras_hit), .ras_empty(ras_empty)
  );

  pc_sequencer #(
    .ADDR_W(16), .INC(4), .RESET_VECTOR(16'hFFF8), .RAS_DEPTH(2)
  ) dut16 (
    .clk(clk), .reset(reset), .stall(s_ctl), .halt(s_ctl), .resume(s_ctl),
    .mode(s_mode), .br_taken(s_ctl), .br_imm(s_imm), .j_target(s_j_target),
    .reg_target(s_reg_target), .call(s_ctl), .ret(s_ctl), .pc_q(s_pc_q),
    .pc_plus(s_pc_plus), .pc_valid(s_pc_valid), .ras_top(s_ras_top),
    .ras_hit(s_ras_hit), .ras_empty(s_ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic tk,
                               input logic [15:0] imm, input logic [25:0] jt,
                               input logic [31:0] rt, input logic st,
                               input logic hl, input logic rs,
                               input logic cl, input logic rn);
    mode = m; br_taken = tk; br_imm = imm; j_target = jt; reg_target = rt;
    stall = st; halt = hl; resume = rs; call = cl; ret = rn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPc(input logic [31:0] addr);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, addr, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Reference next PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] m,
                                           input logic tk, input logic [15:0] imm,
                                           input logic [25:0] jt, input logic [31:0] rt);
    logic [31:0] seq_pc;
    int          offset;
    seq_pc = pc + 32'd4;
    offset = int'($signed(imm)) * 4;
    case (m)
      2'd0:    return seq_pc;
      2'd1:    return tk ? seq_pc + 32'(offset) : seq_pc;
      2'd2:    return (seq_pc & 32'hF000_0000) | (32'(jt) * 32'd4);
      default: return rt;
    endcase
  endfunction

  initial begin
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_top;
    logic [31:0] r_rt;
    logic [1:0]  r_mode;
    logic        r_tk, r_st, r_hl, r_rs, r_cl, r_rn;
    logic [15:0] r_imm;
    logic [25:0] r_jt;
    int          ras_q[$];

    total = 0;
    bad   = 0;
    s_mode = 2'd0; s_ctl = 1'b0; s_imm = 16'h0; s_j_target = 10'h0; s_reg_target = 16'h0;
    reset = 1'b1;
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{"br_taken_neg",  2'd1, 1'b1, 16'hFFFE, 26'h0,       32'h0,    32'h0000_0200, 32'h0000_01FC};
    vecs[1] = '{"br_not_taken",  2'd1, 1'b0, 16'hFFFE, 26'h0,       32'h0,    32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{"jump",          2'd2, 1'b0, 16'h0,    26'h40,      32'h0,    32'h1000_0000, 32'h1000_0100};
    vecs[3] = '{"jreg",          2'd3, 1'b0, 16'h0,    26'h0,       32'hABC0, 32'h1000_0000, 32'h0000_ABC0};
    vecs[4] = '{"seq_wrap",      2'd0, 1'b0, 16'h0,    26'h0,       32'h0,    32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{"br_below_zero", 2'd1, 1'b1, 16'hFFFC, 26'h0,       32'h0,    32'h0000_0004, 32'hFFFF_FFF8};
    vecs[6] = '{"br_max_pos",    2'd1, 1'b1, 16'h7FFF, 26'h0,       32'h0,    32'h0000_0000, 32'h0002_0000};
    vecs[7] = '{"br_max_neg",    2'd1, 1'b1, 16'h8000, 26'h0,       32'h0,    32'h0004_0000, 32'h0002_0004};
    vecs[8] = '{"jump_all_ones", 2'd2, 1'b0, 16'h0,    26'h3FF_FFFF, 32'h0,   32'hF000_0000, 32'hFFFF_FFFC};
    vecs[9] = '{"jump_pc_wrap",  2'd2, 1'b0, 16'h0,    26'h1,       32'h0,    32'hFFFF_FFFC, 32'h0000_0004};

    // Reset state, then BOOT for one cycle, then sequential fetch.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_pc", pc_q, RV);
    checkOutput("reset_valid", {31'b0, pc_valid}, 32'h0);
    checkOutput("reset_ras_empty", {31'b0, ras_empty}, 32'h1);
    checkOutput("reset_ras_top", ras_top, 32'h0);
    checkOutput("reset_ras_hit", {31'b0, ras_hit}, 32'h0);
    checkOutput("reset_pc_plus", pc_plus, 32'h0000_0104);
    reset = 1'b0;
    #1;
    checkOutput("boot_valid", {31'b0, pc_valid}, 32'h0);
    checkOutput("boot_pc", pc_q, RV);
    checkOutput("w16_boot_pc", {16'h0, s_pc_q}, 32'h0000_FFF8);
    tick();
    checkOutput("run0_pc", pc_q, 32'h0000_0100);
    checkOutput("run0_valid", {31'b0, pc_valid}, 32'h1);
    checkOutput("w16_run0_pc", {16'h0, s_pc_q}, 32'h0000_FFF8);
    tick();
    checkOutput("run1_pc", pc_q, 32'h0000_0104);
    checkOutput("w16_run1_pc", {16'h0, s_pc_q}, 32'h0000_FFFC);
    checkOutput("w16_plus_wrap", {16'h0, s_pc_plus}, 32'h0000_0000);
    tick();
    checkOutput("run2_pc", pc_q, 32'h0000_0108);
    checkOutput("w16_wrap_pc", {16'h0, s_pc_q}, 32'h0000_0000);

    // Table of single-step next-PC vectors.
    for (int k = 0; k < 10; k++) begin
      setPc(vecs[k].start);
      checkOutput({vecs[k].name, "_start"}, pc_q, vecs[k].start);
      applyStimulus(vecs[k].mode, vecs[k].taken, vecs[k].imm, vecs[k].jt, vecs[k].rt,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checkOutput({vecs[k].name, "_plus"}, pc_plus, vecs[k].start + 32'd4);
      tick();
      checkOutput(vecs[k].name, pc_q, vecs[k].expect_pc);
    end

    // Stall holds the PC for three cycles.
    setPc(32'h20);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd3, 1'b1, 16'h10, 26'h5, 32'h999, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("stall_pc", pc_q, 32'h20);
      checkOutput("stall_valid", {31'b0, pc_valid}, 32'h1);
    end

    // Halt: the PC advances once more, then fetch is invalid until resume.
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("halt1_pc", pc_q, 32'h24);
    checkOutput("halt1_valid", {31'b0, pc_valid}, 32'h0);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("halt2_pc", pc_q, 32'h24);
    checkOutput("halt2_valid", {31'b0, pc_valid}, 32'h0);
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("resume_pc", pc_q, 32'h24);
    checkOutput("resume_valid", {31'b0, pc_valid}, 32'h1);
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("after_resume_pc", pc_q, 32'h28);

    // halt+resume together: halt wins in RUN, resume wins in HALT.
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("both_run_valid", {31'b0, pc_valid}, 32'h0);
    checkOutput("both_run_pc", pc_q, 32'h2C);
    tick();
    checkOutput("both_halt_valid", {31'b0, pc_valid}, 32'h1);
    checkOutput("both_halt_pc", pc_q, 32'h2C);
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rehalt_valid", {31'b0, pc_valid}, 32'h0);

    // Asynchronous reset in the middle of HALT.
    reset = 1'b1;
    #1;
    checkOutput("async_reset_pc", pc_q, RV);
    checkOutput("async_reset_valid", {31'b0, pc_valid}, 32'h0);
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("reboot_valid", {31'b0, pc_valid}, 32'h0);
    tick();
    checkOutput("rerun_valid", {31'b0, pc_valid}, 32'h1);
    checkOutput("rerun_pc", pc_q, RV);

`ifdef PC_RAS_EN
    // Depth-2 stack: three calls overwrite the oldest, two rets drain it.
    setPc(32'h10);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("ras_full_empty", {31'b0, ras_empty}, 32'h0);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("ras_ret1_top", ras_top, 32'h34);
    checkOutput("ras_ret1_hit", {31'b0, ras_hit}, 32'h1);
    tick();
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("ras_ret2_top", ras_top, 32'h24);
    checkOutput("ras_ret2_hit", {31'b0, ras_hit}, 32'h1);
    checkOutput("ras_ret2_pc", pc_q, 32'h34);
    tick();
    checkOutput("ras_drained_empty", {31'b0, ras_empty}, 32'h1);
    checkOutput("ras_drained_top", ras_top, 32'h0);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("ras_ret3_empty", {31'b0, ras_empty}, 32'h1);
`else
    // Without the stack, calls leave it empty and rets never hit.
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("noras_empty", {31'b0, ras_empty}, 32'h1);
    checkOutput("noras_top", ras_top, 32'h0);
    applyStimulus(2'd3, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("noras_hit", {31'b0, ras_hit}, 32'h0);
`endif

    // Randomized run against the reference model from a fresh reset.
    reset = 1'b1;
    applyStimulus(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    m_phase = 0;
    m_pc    = RV;
    ras_q.delete();
    for (int c = 0; c < 400; c++) begin
      m_top  = (ras_q.size() > 0) ? 32'(ras_q[$]) : 32'h0;
      r_mode = 2'($urandom_range(0, 3));
      r_tk   = 1'($urandom);
      r_imm  = 16'($urandom);
      r_jt   = 26'($urandom);
      r_rt   = ($urandom_range(0, 3) == 0) ? m_top : 32'($urandom);
      r_st   = ($urandom_range(0, 4) == 0);
      r_hl   = ($urandom_range(0, 9) == 0);
      r_rs   = ($urandom_range(0, 2) == 0);
      r_cl   = ($urandom_range(0, 3) == 0);
      r_rn   = ($urandom_range(0, 2) == 0);
      applyStimulus(r_mode, r_tk, r_imm, r_jt, r_rt, r_st, r_hl, r_rs, r_cl, r_rn);
      #1;
      checkOutput("rnd_pc", pc_q, m_pc);
      checkOutput("rnd_plus", pc_plus, m_pc + 32'd4);
      checkOutput("rnd_valid", {31'b0, pc_valid}, {31'b0, m_phase == 1});
`ifdef PC_RAS_EN
      checkOutput("rnd_ras_top", ras_top, m_top);
      checkOutput("rnd_ras_empty", {31'b0, ras_empty}, {31'b0, ras_q.size() == 0});
      checkOutput("rnd_ras_hit", {31'b0, ras_hit}, {31'b0, r_rn && (m_top == r_rt)});
`else
      checkOutput("rnd_ras_top", ras_top, 32'h0);
      checkOutput("rnd_ras_empty", {31'b0, ras_empty}, 32'h1);
      checkOutput("rnd_ras_hit", {31'b0, ras_hit}, 32'h0);
`endif
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (!r_st) begin
          if (r_rn && r_mode == 2'd3 && ras_q.size() > 0) begin
            void'(ras_q.pop_back());
          end
          if (r_cl) begin
            ras_q.push_back(int'(m_pc + 32'd4));
            if (ras_q.size() > 2) begin
              void'(ras_q.pop_front());
            end
          end
          m_pc = ref_next(m_pc, r_mode, r_tk, r_imm, r_jt, r_rt);
          if (r_hl) begin
            m_phase = 2;
          end
        end
      end else if (r_rs) begin
        m_phase = 1;
      end
      tick();
    end
    checkOutput("rnd_final_pc", pc_q, m_pc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
